// File: rtl/sar_pkg.sv
// ============================================================================
// Module      : sar_pkg
// Description : Shared types and helpers for the sar_search controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } sar_state_e;

    // Binary search over 2**n values needs at most n+1 probes.
    function automatic int max_steps(input int n);
        return n + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sar_search.sv
// ============================================================================
// Module      : sar_search
// Description : Successive-approximation search driving an external magnitude
//               comparator; optional one-hot flag check via SAR_ONEHOT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_search
    import sar_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_lt,
    input  logic         cmp_eq,
    input  logic         cmp_gt,
    output logic [N-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [N-1:0] result
`ifdef SAR_ONEHOT_CHECK_EN
    ,
    output logic         cmp_err
`endif
);

    localparam int         MAX_STEPS = max_steps(N);
    localparam int         SW        = $clog2(MAX_STEPS + 1);
    localparam logic [N:0] HI_INIT   = {1'b0, {N{1'b1}}};
    localparam logic [N-1:0] TRIAL_INIT = N'((2**N - 1) / 2);
    localparam logic [N-1:0] TRIAL_MAX  = {N{1'b1}};

    sar_state_e    state_q, state_d;
    logic [N:0]    lo_q, lo_d;
    logic [N:0]    hi_q, hi_d;
    logic [SW-1:0] steps_q, steps_d;
    logic [N-1:0]  trial_q, trial_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          found_q, found_d;
    logic [N-1:0]  result_q, result_d;
`ifdef SAR_ONEHOT_CHECK_EN
    logic          err_q, err_d;
`endif

    logic [N:0]    w_trial_ext;
    logic [N:0]    w_sum;
    logic          w_none;
    logic          w_gt_path;
    logic          w_hit;
    logic          w_miss;

    assign w_trial_ext = {1'b0, trial_q};
    assign w_none      = !cmp_lt && !cmp_eq && !cmp_gt;
    // With eq and lt already ruled out, a missing flag falls into the gt path.
    assign w_gt_path   = cmp_gt || w_none;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        steps_d  = steps_q;
        trial_d  = trial_q;
        busy_d   = busy_q;
        done_d   = done_q;
        found_d  = found_q;
        result_d = result_q;
`ifdef SAR_ONEHOT_CHECK_EN
        err_d    = err_q;
`endif
        w_sum    = '0;
        w_hit    = 1'b0;
        w_miss   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = COMPARE;
                    lo_d     = '0;
                    hi_d     = HI_INIT;
                    trial_d  = TRIAL_INIT;
                    steps_d  = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    found_d  = 1'b0;
                    result_d = '0;
`ifdef SAR_ONEHOT_CHECK_EN
                    err_d    = 1'b0;
`endif
                end
            end

            COMPARE: begin
`ifdef SAR_ONEHOT_CHECK_EN
                if ({cmp_lt, cmp_eq, cmp_gt} != 3'b100 &&
                    {cmp_lt, cmp_eq, cmp_gt} != 3'b010 &&
                    {cmp_lt, cmp_eq, cmp_gt} != 3'b001) begin
                    err_d  = 1'b1;
                    w_miss = 1'b1;
                end else
`endif
                if (cmp_eq) begin
                    w_hit = 1'b1;
                end else if (cmp_lt) begin
                    if (trial_q == TRIAL_MAX) begin
                        w_miss = 1'b1;
                    end else begin
                        lo_d = w_trial_ext + 1'b1;
                    end
                end else if (w_gt_path) begin
                    if (trial_q == '0) begin
                        w_miss = 1'b1;
                    end else begin
                        hi_d = w_trial_ext - 1'b1;
                    end
                end

                if (!w_hit && !w_miss &&
                    ((lo_d > hi_d) || ((steps_q + 1'b1) == SW'(MAX_STEPS)))) begin
                    w_miss = 1'b1;
                end

                steps_d = steps_q + 1'b1;
                // Sum is N+1 bits wide so lo+hi never wraps.
                w_sum   = lo_d + hi_d;

                if (w_hit || w_miss) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    found_d  = w_hit;
                    result_d = w_hit ? trial_q : '0;
                end else begin
                    trial_d  = w_sum[N:1];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            steps_q  <= '0;
            trial_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            result_q <= '0;
`ifdef SAR_ONEHOT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            steps_q  <= steps_d;
            trial_q  <= trial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            result_q <= result_d;
`ifdef SAR_ONEHOT_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign trial  = trial_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign result = result_q;
`ifdef SAR_ONEHOT_CHECK_EN
    assign cmp_err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// ============================================================================
// Module      : tb_sar_search
// Description : Directed self-checking bench for sar_search (N=4) with an
//               in-bench comparator model; honours SAR_ONEHOT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cmp_lt;
    logic       cmp_eq;
    logic       cmp_gt;
    logic [3:0] trial;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] result;
`ifdef SAR_ONEHOT_CHECK_EN
    logic       cmp_err;
`endif

    logic [3:0] target;
    int         mode;
    int         total;
    int         bad;
    logic [3:0] tv [8];

    sar_search #(.N(4)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result)
`ifdef SAR_ONEHOT_CHECK_EN
        ,
        .cmp_err(cmp_err)
`endif
    );

    // Comparator: mode 0 real compare, 1 stuck lt, 2 no flags, 3 all flags.
    always_comb begin
        cmp_lt = 1'b0;
        cmp_eq = 1'b0;
        cmp_gt = 1'b0;
        case (mode)
            0: begin
                cmp_lt = trial < target;
                cmp_eq = trial == target;
                cmp_gt = trial > target;
            end
            1: cmp_lt = 1'b1;
            3: begin
                cmp_lt = 1'b1;
                cmp_eq = 1'b1;
                cmp_gt = 1'b1;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then check every compare cycle and the completion cycle.
    task automatic run_search(input logic [3:0] tgt, input int m, input logic [3:0] tr [8],
                              input int k, input logic exp_found, input logic [3:0] exp_res,
                              input bit poke);
        target = tgt;
        mode   = m;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < k; i++) begin
            chk($sformatf("trial[%0d] tgt=%0d", i, tgt), 32'(trial), 32'(tr[i]));
            chk($sformatf("busy[%0d] tgt=%0d", i, tgt), 32'(busy), 32'd1);
            chk($sformatf("done_low[%0d] tgt=%0d", i, tgt), 32'(done), 32'd0);
            start = poke && (i == 1);
            tick();
            start = 1'b0;
        end
        chk($sformatf("done tgt=%0d", tgt), 32'(done), 32'd1);
        chk($sformatf("busy_low tgt=%0d", tgt), 32'(busy), 32'd0);
        chk($sformatf("found tgt=%0d", tgt), 32'(found), 32'(exp_found));
        chk($sformatf("result tgt=%0d", tgt), 32'(result), 32'(exp_res));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        target = 4'd0;
        mode   = 0;
        tick();
        tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset found", 32'(found), 32'd0);
        chk("reset trial", 32'(trial), 32'd0);
        chk("reset result", 32'(result), 32'd0);
`ifdef SAR_ONEHOT_CHECK_EN
        chk("reset cmp_err", 32'(cmp_err), 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk("idle done", 32'(done), 32'd0);

        tv = '{4'd7, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_search(4'd5, 0, tv, 3, 1'b1, 4'd5, 1'b0);
        tick();
        chk("done hold", 32'(done), 32'd1);
        chk("result hold", 32'(result), 32'd5);
        chk("trial hold", 32'(trial), 32'd5);

        // Starts from DONE; done must drop on the first compare cycle.
        tv = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0, 4'd0, 4'd0};
        run_search(4'd15, 0, tv, 5, 1'b1, 4'd15, 1'b0);

        tv = '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_search(4'd0, 0, tv, 4, 1'b1, 4'd0, 1'b0);

        tv = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0, 4'd0, 4'd0};
        run_search(4'd0, 1, tv, 5, 1'b0, 4'd0, 1'b0);
        chk("stuck trial hold", 32'(trial), 32'd15);

        // Start pulsed mid-search must be ignored.
        tv = '{4'd7, 4'd11, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_search(4'd9, 0, tv, 3, 1'b1, 4'd9, 1'b1);

`ifdef SAR_ONEHOT_CHECK_EN
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err low t+1", 32'(cmp_err), 32'd0);
        tick();
        chk("cmp_err t+2", 32'(cmp_err), 32'd1);
        chk("err done", 32'(done), 32'd1);
        chk("err found", 32'(found), 32'd0);
        chk("err result", 32'(result), 32'd0);
        tick();
        chk("cmp_err sticky", 32'(cmp_err), 32'd1);
        mode  = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err cleared by start", 32'(cmp_err), 32'd0);
        tick();
        chk("multi-flag err", 32'(cmp_err), 32'd1);
        chk("multi-flag found", 32'(found), 32'd0);
`else
        // No flags behaves as gt; all flags resolves to eq.
        tv = '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_search(4'd0, 2, tv, 4, 1'b0, 4'd0, 1'b0);
        tv = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_search(4'd0, 3, tv, 1, 1'b1, 4'd7, 1'b0);
`endif

        // Reset asserted mid-search at t+2.
        mode   = 0;
        target = 4'd5;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        rst    = 1'b1;
        start  = 1'b1;
        tick();
        rst    = 1'b0;
        start  = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst found", 32'(found), 32'd0);
        chk("midrst trial", 32'(trial), 32'd0);
        chk("midrst result", 32'(result), 32'd0);
        tick();
        chk("midrst idle", 32'(busy), 32'd0);

        tv = '{4'd7, 4'd11, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        run_search(4'd9, 0, tv, 3, 1'b1, 4'd9, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
